// File: rtl/windowed_peak_hold.sv
// Windowed peak detector. It collects WINDOW_LEN accepted signed samples and reports the
// window maximum or minimum, and that sample's position in the window, with a one-cycle valid pulse.
module windowed_peak_hold #(
   parameter int DATA_WIDTH = 11,
   parameter int WINDOW_LEN = 256,
   localparam int CNT_WIDTH = $clog2(WINDOW_LEN)
) (
   input  logic                         i_clk,
   input  logic                         i_nrst,
   input  logic                         i_ce,
   input  logic                         i_mode,
   input  logic                         i_clear,
   input  logic signed [DATA_WIDTH-1:0] i_signal,
   input  logic                         i_signal_valid,
   output logic signed [DATA_WIDTH-1:0] o_peak,
   output logic        [CNT_WIDTH-1:0]  o_peak_idx,
   output logic                         o_peak_valid,
   output logic                         o_busy
);

   if (WINDOW_LEN < 2) begin : g_window_len_check
      $error("windowed_peak_hold: WINDOW_LEN must be >= 2");
   end

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] TRACK = 1'b1;

   localparam logic [CNT_WIDTH-1:0] LAST_POS = CNT_WIDTH'(WINDOW_LEN - 1);

   logic [0:0]                   state;
   logic signed [DATA_WIDTH-1:0] run_peak;
   logic [CNT_WIDTH-1:0]         run_idx;
   logic [CNT_WIDTH-1:0]         count;
   logic                         mode_q;

   logic                         accept;
   logic                         sample_wins;
   logic signed [DATA_WIDTH-1:0] next_peak;
   logic [CNT_WIDTH-1:0]         next_idx;

   assign accept = i_ce & i_signal_valid;
   assign o_busy = (state == TRACK);

   // Strict compare keeps the earliest index on ties; mode_q was latched at window start.
   always_comb begin
      sample_wins = 1'b0;
      if (mode_q) begin
         sample_wins = (i_signal < run_peak);
      end else begin
         sample_wins = (i_signal > run_peak);
      end
      next_peak = sample_wins ? i_signal : run_peak;
      next_idx  = sample_wins ? count : run_idx;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state        <= IDLE;
         run_peak     <= '0;
         run_idx      <= '0;
         count        <= '0;
         mode_q       <= 1'b0;
         o_peak       <= '0;
         o_peak_idx   <= '0;
         o_peak_valid <= 1'b0;
      end else begin
         o_peak_valid <= 1'b0;
         // Clear wins over a simultaneous accept, including the last sample of a window.
         if (i_clear) begin
            state <= IDLE;
            count <= '0;
         end else if (accept) begin
            case (state)
               IDLE: begin
                  run_peak <= i_signal;
                  run_idx  <= '0;
                  count    <= CNT_WIDTH'(1);
                  mode_q   <= i_mode;
                  state    <= TRACK;
               end
               TRACK: begin
                  if (count == LAST_POS) begin
                     o_peak       <= next_peak;
                     o_peak_idx   <= next_idx;
                     o_peak_valid <= 1'b1;
                     count        <= '0;
                     state        <= IDLE;
                  end else begin
                     run_peak <= next_peak;
                     run_idx  <= next_idx;
                     count    <= count + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  count <= '0;
               end
            endcase
         end
      end
   end

endmodule
